// File: rtl/seven_segment_pkg.sv
// Shared segment types, glyph constants and the BCD decode function.
// Hex glyphs for codes 10..15 are enabled by defining SEVEN_SEGMENT_HEX_DIGITS_EN.
package seven_segment_pkg;

  // Bit 6 = segment A (top) ... bit 0 = segment G (middle); 1 = lit.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK   = 7'b0000000;

  localparam seg_t SEG_DIGIT_0 = 7'b1111110;
  localparam seg_t SEG_DIGIT_1 = 7'b0110000;
  localparam seg_t SEG_DIGIT_2 = 7'b1101101;
  localparam seg_t SEG_DIGIT_3 = 7'b1111001;
  localparam seg_t SEG_DIGIT_4 = 7'b0110011;
  localparam seg_t SEG_DIGIT_5 = 7'b1011011;
  localparam seg_t SEG_DIGIT_6 = 7'b1011111;
  localparam seg_t SEG_DIGIT_7 = 7'b1110000;
  localparam seg_t SEG_DIGIT_8 = 7'b1111111;
  localparam seg_t SEG_DIGIT_9 = 7'b1111011;

  localparam seg_t SEG_HEX_A   = 7'b1110111;
  localparam seg_t SEG_HEX_B   = 7'b0011111;
  localparam seg_t SEG_HEX_C   = 7'b1001110;
  localparam seg_t SEG_HEX_D   = 7'b0111101;
  localparam seg_t SEG_HEX_E   = 7'b1001111;
  localparam seg_t SEG_HEX_F   = 7'b1000111;

  function automatic seg_t decode_bcd(logic [3:0] code);
    seg_t seg;
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_DIGIT_0;
      4'd1:    seg = SEG_DIGIT_1;
      4'd2:    seg = SEG_DIGIT_2;
      4'd3:    seg = SEG_DIGIT_3;
      4'd4:    seg = SEG_DIGIT_4;
      4'd5:    seg = SEG_DIGIT_5;
      4'd6:    seg = SEG_DIGIT_6;
      4'd7:    seg = SEG_DIGIT_7;
      4'd8:    seg = SEG_DIGIT_8;
      4'd9:    seg = SEG_DIGIT_9;
`ifdef SEVEN_SEGMENT_HEX_DIGITS_EN
      4'd10:   seg = SEG_HEX_A;
      4'd11:   seg = SEG_HEX_B;
      4'd12:   seg = SEG_HEX_C;
      4'd13:   seg = SEG_HEX_D;
      4'd14:   seg = SEG_HEX_E;
      4'd15:   seg = SEG_HEX_F;
`endif
      // Invalid BCD (and unknown inputs) fall through to a blank digit.
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Purely combinational 4-to-7 segment table; no state.
// Build option SEVEN_SEGMENT_HEX_DIGITS_EN is handled inside decode_bcd.
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  assign seg = decode_bcd(code);

endmodule

// File: rtl/seven_segment.sv
// Registered BCD-to-seven-segment decoder (common-cathode, active-high segments).
// Define SEVEN_SEGMENT_HEX_DIGITS_EN to show hex glyphs for codes 10..15.
module seven_segment
  import seven_segment_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic W,
  input  logic X,
  input  logic Y,
  input  logic Z,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G
);

  seg_t seg_d;
  seg_t seg_p0;

  seven_segment_decode u_decode (
    .code ({W, X, Y, Z}),
    .seg  (seg_d)
  );

  // Stage p0: output flop; reset blanks the display without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0 <= SEG_BLANK;
    end else begin
      seg_p0 <= seg_d;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_p0;

endmodule

// File: tb/tb_seven_segment.sv
// Directed + randomized bench for seven_segment; expected glyphs are built
// from the lit-segment letters of each character.
module tb_seven_segment;

  logic clk;
  logic rst_n;
  logic W, X, Y, Z;
  logic A, B, C, D, E, F, G;

  int checks;
  int passed;
  int fails;

  seven_segment dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (W),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .G     (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment letters lit for each character, as seen on the display.
  function automatic string lit_letters(int code);
    case (code)
      0:  return "abcdef";
      1:  return "bc";
      2:  return "abdeg";
      3:  return "abcdg";
      4:  return "bcfg";
      5:  return "acdfg";
      6:  return "acdefg";
      7:  return "abc";
      8:  return "abcdefg";
      9:  return "abcdfg";
`ifdef SEVEN_SEGMENT_HEX_DIGITS_EN
      10: return "abcefg";
      11: return "cdefg";
      12: return "adef";
      13: return "bcdeg";
      14: return "adefg";
      15: return "aefg";
`endif
      default: return "";
    endcase
  endfunction

  function automatic logic [6:0] model(int code);
    logic [6:0] v;
    string s;
    v = 7'b0;
    s = lit_letters(code);
    for (int i = 0; i < s.len(); i++) begin
      v[6 - int'(s[i] - "a")] = 1'b1;
    end
    return v;
  endfunction

  task automatic set_code(input int code);
    {W, X, Y, Z} = 4'(code);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {A, B, C, D, E, F, G};
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: ABCDEFG=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int code;
    checks = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b1;
    set_code(8);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 7'b0000000);

    // Reset held across several edges with input 8.
    repeat (3) begin
      tick();
      check("reset_hold", 7'b0000000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset_release_8", model(8));
    check("reset_release_8_lit", 7'b1111111);

    // Full sweep of every code, one per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_code(i);
      tick();
      check($sformatf("sweep_%0d", i), model(i));
    end

    // Spot checks against literal table entries.
    @(negedge clk); set_code(0); tick(); check("lit_0", 7'b1111110);
    @(negedge clk); set_code(2); tick(); check("lit_2", 7'b1101101);
    @(negedge clk); set_code(9); tick(); check("lit_9", 7'b1111011);
`ifdef SEVEN_SEGMENT_HEX_DIGITS_EN
    @(negedge clk); set_code(10); tick(); check("lit_10", 7'b1110111);
    @(negedge clk); set_code(15); tick(); check("lit_15", 7'b1000111);
`else
    @(negedge clk); set_code(10); tick(); check("lit_10", 7'b0000000);
    @(negedge clk); set_code(15); tick(); check("lit_15", 7'b0000000);
`endif

    // Input change between edges must not reach the outputs early.
    @(negedge clk);
    set_code(3);
    tick();
    check("latency_3", 7'b1111001);
    #3 set_code(4);
    #1 check("latency_hold_3", 7'b1111001);
    tick();
    check("latency_4", 7'b0110011);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    set_code(5);
    tick();
    check("async_pre_5", 7'b1011011);
    #2 rst_n = 1'b0;
    #1 check("async_blank", 7'b0000000);
    @(negedge clk);
    check("async_blank_hold", 7'b0000000);
    rst_n = 1'b1;
    #1 check("async_release_no_edge", 7'b0000000);
    tick();
    check("async_post_5", 7'b1011011);

    // Randomized codes against the model.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      code = int'($urandom_range(15, 0));
      set_code(code);
      tick();
      check($sformatf("rand_%0d_code_%0d", i, code), model(code));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment.md
Name: seven_segment

Overview:
- Registered BCD-to-seven-segment decoder.
- Takes a 4-bit BCD digit on W (MSB), X, Y, Z and drives the seven segment enables A..G of a single display digit.
- Sits between BCD counter/arithmetic logic and the display pins.
- Outputs are flopped on the clock for glitch-free segment drive.

Parameters:
- None. Segment polarity is fixed active-high (common-cathode); a segment is lit when its bit = 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- W  input  1  BCD bit 3 (MSB, weight 8).
- X  input  1  BCD bit 2 (weight 4).
- Y  input  1  BCD bit 1 (weight 2).
- Z  input  1  BCD bit 0 (LSB, weight 1).
- A  output  1  segment a (top).
- B  output  1  segment b (upper right).
- C  output  1  segment c (lower right).
- D  output  1  segment d (bottom).
- E  output  1  segment e (lower left).
- F  output  1  segment f (upper left).
- G  output  1  segment g (middle).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n = 0, A..G = 0 (display blank), asserted immediately without waiting for clk. After deassertion, the first rising edge loads the decode of the current input.
- Latency: 1 cycle. The value {W,X,Y,Z} sampled at rising edge n appears on A..G after edge n and holds until the next edge. No handshake; every edge samples.
- Decode table, code -> ABCDEFG:
  - 0 -> 1111110
  - 1 -> 0110000
  - 2 -> 1101101
  - 3 -> 1111001
  - 4 -> 0110011
  - 5 -> 1011011
  - 6 -> 1011111 (with top tail)
  - 7 -> 1110000
  - 8 -> 1111111
  - 9 -> 1111011 (with bottom tail)
- Codes 10..15 are invalid BCD -> 0000000 (blank), unless HEX_DIGITS_EN is defined.
- X/Z on any input: outputs are don't-care, but no latch is inferred. The decode is a full case with a default.
- Reset asserted mid-stream blanks the outputs at once. Input changes between edges have no effect on the outputs.

Optional Feature:
- Macro: SEVEN_SEGMENT_HEX_DIGITS_EN.
- Defined: codes 10..15 display hex glyphs:
  - 10 (A) -> 1110111
  - 11 (b) -> 0011111
  - 12 (C) -> 1001110
  - 13 (d) -> 0111101
  - 14 (E) -> 1001111
  - 15 (F) -> 1000111
- Not defined: codes 10..15 -> 0000000.
- Codes 0..9 are identical in both builds.

Decomposition:
- Package seven_segment_pkg holds:
  - typedef seg_t (7-bit, bit 6 = A ... bit 0 = G);
  - constants SEG_BLANK and SEG_DIGIT_0..SEG_DIGIT_9, plus SEG_HEX_A..SEG_HEX_F;
  - a pure function decode_bcd(logic [3:0]) -> seg_t, with the hex branch under the macro.
- Optional sub-module seven_segment_decode: purely combinational 4-to-7 table. The top module adds only the register stage and reset.

Test Plan:
- Reset: hold rst_n = 0 with input 8 (1000) -> A..G = 0000000 continuously. Release, then one edge -> 1111111.
- Sweep 0..9, one code per cycle -> after each edge, outputs match the table. E.g. 0 -> 1111110, 1 -> 0110000, 2 -> 1101101, 7 -> 1110000, 9 -> 1111011.
- Latency: change input 3 -> 4 midway between edges -> outputs stay 1111001 until the next edge, then 0110011.
- Invalid codes 10..15, macro undefined -> 0000000 each. Same sweep with macro defined -> 10 -> 1110111, 15 -> 1000111.
- Async reset mid-stream: input 5 showing 1011011, pulse rst_n low between edges -> outputs 0000000 immediately, with no clk edge needed. After release, next edge -> 1011011.
